// File: rtl/directory_home_controller_pkg.sv
// directory_pkg: shared encodings for the directory home controller and the cache FSMs
package directory_pkg;
  typedef enum logic [1:0] {
    DIR_UNCACHED  = 2'b00,
    DIR_SHARED    = 2'b10,
    DIR_EXCLUSIVE = 2'b11
  } dir_state_e;
  typedef enum logic [1:0] {
    REQ_NONE       = 2'b00,
    REQ_READ_MISS  = 2'b01,
    REQ_WRITE_MISS = 2'b10,
    REQ_INVALIDATE = 2'b11
  } req_type_e;
  localparam logic [1:0] CPU_INVALID  = 2'b01;
  localparam logic [1:0] CPU_SHARED   = 2'b10;
  localparam logic [1:0] CPU_MODIFIED = 2'b11;
  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_INVAL, S_FETCH, S_WAIT_WB, S_REPLY
  } ctrl_state_e;
endpackage

// File: rtl/directory_home_controller_if.sv
// directory_home_controller_if: request, invalidate, fetch and reply signals of the home node
interface directory_home_controller_if #(
  parameter int NUM_CPUS   = 4,
  parameter int NUM_BLOCKS = 16
);
  localparam int ADDR_W = $clog2(NUM_BLOCKS);
  localparam int CPU_W  = $clog2(NUM_CPUS);
  logic                reqValid;
  logic                reqReady;
  logic [1:0]          reqType;
  logic [CPU_W-1:0]    reqCpu;
  logic [ADDR_W-1:0]   reqAddr;
  logic                invalValid;
  logic [NUM_CPUS-1:0] invalMask;
  logic                fetchValid;
  logic [CPU_W-1:0]    fetchCpu;
  logic                fetchInvalidate;
  logic                wbDone;
  logic                replyValid;
  logic                replyReady;
  logic [CPU_W-1:0]    replyCpu;
  logic [ADDR_W-1:0]   replyAddr;
  logic                replyExclusive;
  logic [ADDR_W-1:0]   addrOut;
  modport master (
    output reqValid, reqType, reqCpu, reqAddr, wbDone, replyReady,
    input  reqReady, invalValid, invalMask, fetchValid, fetchCpu, fetchInvalidate,
           replyValid, replyCpu, replyAddr, replyExclusive, addrOut
  );
  modport slave (
    input  reqValid, reqType, reqCpu, reqAddr, wbDone, replyReady,
    output reqReady, invalValid, invalMask, fetchValid, fetchCpu, fetchInvalidate,
           replyValid, replyCpu, replyAddr, replyExclusive, addrOut
  );
endinterface

// File: rtl/directory_home_controller_entry_array.sv
// directory_entry_array: per-block directory state and sharer vector, registered read, single write
module directory_entry_array #(
  parameter int NUM_CPUS   = 4,
  parameter int NUM_BLOCKS = 16,
  parameter int ADDR_W     = $clog2(NUM_BLOCKS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic [1:0]          rd_state_o,
  output logic [NUM_CPUS-1:0] rd_sharers_o,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [1:0]          wr_state_i,
  input  logic [NUM_CPUS-1:0] wr_sharers_i
);
  logic [1:0]          state_q   [NUM_BLOCKS];
  logic [NUM_CPUS-1:0] sharers_q [NUM_BLOCKS];
  // storage update plus registered read; reset returns every block to UNCACHED with no sharers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        state_q[i]   <= '0;
        sharers_q[i] <= '0;
      end
      rd_state_o   <= '0;
      rd_sharers_o <= '0;
    end else begin
      rd_state_o   <= state_q[rd_addr_i];
      rd_sharers_o <= sharers_q[rd_addr_i];
      if (we_i) begin
        state_q[wr_addr_i]   <= wr_state_i;
        sharers_q[wr_addr_i] <= wr_sharers_i;
      end
    end
  end
endmodule

// File: rtl/directory_home_controller.sv
// directory_home_controller: serialising home-node directory; optional DIRECTORY_STATS_EN adds event counters
module directory_home_controller
  import directory_pkg::*;
#(
  parameter int NUM_CPUS   = 4,
  parameter int NUM_BLOCKS = 16
) (
  input logic clk,
  input logic rst_n,
  directory_home_controller_if.slave bus
`ifdef DIRECTORY_STATS_EN
  ,
  output logic [15:0] statReqCount,
  output logic [15:0] statInvalCount,
  output logic [15:0] statFetchCount
`endif
);
  localparam int ADDR_W = $clog2(NUM_BLOCKS);
  localparam int CPU_W  = $clog2(NUM_CPUS);
  ctrl_state_e         state_q, state_d;
  logic [1:0]          type_q, type_d;
  logic [CPU_W-1:0]    cpu_q, cpu_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  dir_state_e          new_state_q, new_state_d;
  logic [NUM_CPUS-1:0] new_sh_q, new_sh_d;
  logic [NUM_CPUS-1:0] mask_q, mask_d;
  logic [CPU_W-1:0]    owner_q, owner_d;
  logic                finv_q, finv_d;
  logic                excl_q, excl_d;
  logic [1:0]          rd_state;
  logic [NUM_CPUS-1:0] rd_sh;
  logic [CPU_W-1:0]    owner_idx;
  logic [NUM_CPUS-1:0] r_bit;
  logic                accept, wr_req, we;
  assign accept = bus.reqValid && state_q == S_IDLE;
  assign r_bit  = NUM_CPUS'(1) << cpu_q;
  assign wr_req = type_q != REQ_READ_MISS;
  assign we     = state_d == S_REPLY && state_q != S_REPLY;
  directory_entry_array #(.NUM_CPUS(NUM_CPUS), .NUM_BLOCKS(NUM_BLOCKS), .ADDR_W(ADDR_W)) u_arr (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_addr_i    (state_q == S_IDLE ? bus.reqAddr : addr_q),
    .rd_state_o   (rd_state),
    .rd_sharers_o (rd_sh),
    .we_i         (we),
    .wr_addr_i    (addr_q),
    .wr_state_i   (new_state_d),
    .wr_sharers_i (new_sh_d)
  );
  // an EXCLUSIVE entry has a single sharer bit; turn it into the owner's index
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_CPUS; i++) if (rd_sh[i]) owner_idx = CPU_W'(i);
  end
  // next state and the per-request working registers
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    cpu_d       = cpu_q;
    addr_d      = addr_q;
    new_state_d = new_state_q;
    new_sh_d    = new_sh_q;
    mask_d      = mask_q;
    owner_d     = owner_q;
    finv_d      = finv_q;
    excl_d      = excl_q;
    case (state_q)
      S_IDLE: if (accept && bus.reqType != REQ_NONE) begin
        type_d  = bus.reqType;
        cpu_d   = bus.reqCpu;
        addr_d  = bus.reqAddr;
        state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        excl_d      = wr_req;
        finv_d      = wr_req;
        owner_d     = owner_idx;
        new_state_d = wr_req ? DIR_EXCLUSIVE : DIR_SHARED;
        new_sh_d    = wr_req ? r_bit : rd_sh | r_bit;
        mask_d      = rd_state == DIR_SHARED && wr_req ? rd_sh & ~r_bit : '0;
        state_d     = mask_d != '0 ? S_INVAL :
                      rd_state == DIR_EXCLUSIVE && rd_sh != r_bit ? S_FETCH : S_REPLY;
      end
      S_INVAL:   state_d = S_REPLY;
      S_FETCH:   state_d = S_WAIT_WB;
      S_WAIT_WB: state_d = bus.wbDone ? S_REPLY : S_WAIT_WB;
      S_REPLY:   state_d = bus.replyReady ? S_IDLE : S_REPLY;
      default:   state_d = S_IDLE;
    endcase
  end
  // controller state and request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      type_q      <= '0;
      cpu_q       <= '0;
      addr_q      <= '0;
      new_state_q <= DIR_UNCACHED;
      new_sh_q    <= '0;
      mask_q      <= '0;
      owner_q     <= '0;
      finv_q      <= 1'b0;
      excl_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      cpu_q       <= cpu_d;
      addr_q      <= addr_d;
      new_state_q <= new_state_d;
      new_sh_q    <= new_sh_d;
      mask_q      <= mask_d;
      owner_q     <= owner_d;
      finv_q      <= finv_d;
      excl_q      <= excl_d;
    end
  end
  assign bus.reqReady        = state_q == S_IDLE;
  assign bus.invalValid      = state_q == S_INVAL;
  assign bus.invalMask       = state_q == S_INVAL ? mask_q : '0;
  assign bus.fetchValid      = state_q == S_FETCH;
  assign bus.fetchCpu        = owner_q;
  assign bus.fetchInvalidate = state_q == S_FETCH && finv_q;
  assign bus.replyValid      = state_q == S_REPLY;
  assign bus.replyCpu        = cpu_q;
  assign bus.replyAddr       = addr_q;
  assign bus.replyExclusive  = state_q == S_REPLY && excl_q;
  assign bus.addrOut         = addr_q;
`ifdef DIRECTORY_STATS_EN
  logic [15:0] req_cnt_q, inval_cnt_q, fetch_cnt_q;
  // saturating counts of accepted real requests, invalidate pulses and fetch pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt_q   <= '0;
      inval_cnt_q <= '0;
      fetch_cnt_q <= '0;
    end else begin
      if (accept && bus.reqType != REQ_NONE && req_cnt_q != 16'hFFFF) req_cnt_q <= req_cnt_q + 16'd1;
      if (state_q == S_INVAL && inval_cnt_q != 16'hFFFF) inval_cnt_q <= inval_cnt_q + 16'd1;
      if (state_q == S_FETCH && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'd1;
    end
  end
  assign statReqCount   = req_cnt_q;
  assign statInvalCount = inval_cnt_q;
  assign statFetchCount = fetch_cnt_q;
`endif
endmodule

// File: tb/tb_directory_home_controller.sv
// tb_directory_home_controller: directed and randomized checks against a directory reference model
module tb_directory_home_controller;
  import directory_pkg::*;
  localparam int NC = 4;
  localparam int NB = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  directory_home_controller_if #(.NUM_CPUS(NC), .NUM_BLOCKS(NB)) bus ();
`ifdef DIRECTORY_STATS_EN
  logic [15:0] s_req, s_inv, s_fet;
  directory_home_controller #(.NUM_CPUS(NC), .NUM_BLOCKS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .statReqCount(s_req), .statInvalCount(s_inv), .statFetchCount(s_fet));
`else
  directory_home_controller #(.NUM_CPUS(NC), .NUM_BLOCKS(NB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  int passed = 0;
  int total = 0;
  logic [1:0] m_st [NB];
  logic [3:0] m_sh [NB];
  int x_act, x_owner;
  logic [3:0] x_mask, x_sh;
  logic [1:0] x_st;
  bit x_finv, x_excl;
  int o_inval_cyc, o_inval_n, o_fetch_cyc, o_fetch_n, o_reply_cyc;
  logic [3:0] o_mask, o_raddr;
  logic [1:0] o_fcpu, o_rcpu;
  logic o_finv, o_excl;
  bit o_stable, o_idle_after;

  // directory rules: what a request to block a by cpu c should do and leave behind
  function automatic void predict(input logic [1:0] t, input int c, input int a);
    logic [3:0] r = 4'(1 << c);
    bit wr = (t != REQ_READ_MISS);
    int own = -1;
    x_act = 0; x_mask = 0; x_owner = 0; x_finv = 0; x_excl = wr;
    x_st = m_st[a]; x_sh = m_sh[a];
    if (t == REQ_NONE) begin x_excl = 0; return; end
    for (int i = 0; i < NC; i++) if (m_sh[a][i]) own = i;
    x_st = wr ? DIR_EXCLUSIVE : DIR_SHARED;
    if (m_st[a] == DIR_SHARED && wr) begin
      x_mask = m_sh[a] & ~r;
      x_act = (x_mask != 0) ? 1 : 0;
      x_sh = r;
    end else if (m_st[a] == DIR_SHARED) x_sh = m_sh[a] | r;
    else if (m_st[a] == DIR_EXCLUSIVE && own != c) begin
      x_act = 2; x_owner = own; x_finv = wr;
      x_sh = wr ? r : m_sh[a] | r;
    end else x_sh = r;
  endfunction

  // drives one request, plays the owner (wbDone) and the requester (replyReady), records what happened
  task automatic run_req(input logic [1:0] t, input int c, input int a, input int d, input bit early, input int hold);
    predict(t, c, a);
    o_inval_cyc = -1; o_inval_n = 0; o_fetch_cyc = -1; o_fetch_n = 0; o_reply_cyc = -1;
    o_mask = 0; o_fcpu = 0; o_finv = 0; o_rcpu = 0; o_raddr = 0; o_excl = 0;
    o_stable = 1; o_idle_after = 0;
    @(negedge clk);
    bus.reqValid = 1; bus.reqType = t; bus.reqCpu = 2'(c); bus.reqAddr = 4'(a);
    @(negedge clk);
    bus.reqValid = 0; bus.reqType = 0;
    for (int k = 1; k <= 60; k++) begin
      if (bus.invalValid) begin
        o_inval_n++;
        if (o_inval_cyc < 0) begin o_inval_cyc = k; o_mask = bus.invalMask; end
      end
      if (bus.fetchValid) begin
        o_fetch_n++;
        if (o_fetch_cyc < 0) begin o_fetch_cyc = k; o_fcpu = bus.fetchCpu; o_finv = bus.fetchInvalidate; end
      end
      bus.wbDone = (o_fetch_cyc >= 0) && ((k == o_fetch_cyc + d) || (early && k == o_fetch_cyc));
      if (bus.replyValid) begin
        if (o_reply_cyc < 0) begin
          o_reply_cyc = k; o_rcpu = bus.replyCpu; o_raddr = bus.replyAddr; o_excl = bus.replyExclusive;
        end else if (o_rcpu !== bus.replyCpu || o_raddr !== bus.replyAddr || o_excl !== bus.replyExclusive) o_stable = 0;
        if (bus.reqReady) o_stable = 0;
        if (k - o_reply_cyc >= hold) begin
          bus.replyReady = 1;
          @(negedge clk);
          bus.replyReady = 0;
          o_idle_after = !bus.replyValid && bus.reqReady;
          break;
        end
      end
      if (t == REQ_NONE && k >= 6) break;
      @(negedge clk);
    end
    bus.wbDone = 0;
    if (t != REQ_NONE) begin m_st[a] = x_st; m_sh[a] = x_sh; end
  endtask

  task automatic test_reset();
    bus.reqValid = 0; bus.reqType = 0; bus.reqCpu = 0; bus.reqAddr = 0; bus.wbDone = 0; bus.replyReady = 0;
    for (int i = 0; i < NB; i++) begin m_st[i] = 0; m_sh[i] = 0; end
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    total++; if (bus.reqReady !== 1'b1) $display("FAIL reset_reqReady: got %b expected 1", bus.reqReady); else passed++;
    total++; if (bus.invalValid !== 1'b0) $display("FAIL reset_invalValid: got %b expected 0", bus.invalValid); else passed++;
    total++; if (bus.fetchValid !== 1'b0) $display("FAIL reset_fetchValid: got %b expected 0", bus.fetchValid); else passed++;
    total++; if (bus.replyValid !== 1'b0) $display("FAIL reset_replyValid: got %b expected 0", bus.replyValid); else passed++;
    total++; if (bus.replyExclusive !== 1'b0) $display("FAIL reset_replyExclusive: got %b expected 0", bus.replyExclusive); else passed++;
    total++; if (bus.invalMask !== 4'b0) $display("FAIL reset_invalMask: got %b expected 0", bus.invalMask); else passed++;
    total++; if ({bus.fetchCpu, bus.replyCpu, bus.replyAddr, bus.addrOut} !== 12'b0)
      $display("FAIL reset_addr_cpu: got %h expected 0", {bus.fetchCpu, bus.replyCpu, bus.replyAddr, bus.addrOut}); else passed++;
    for (int i = 0; i < NB; i++) begin
      total++; if ({dut.u_arr.state_q[i], dut.u_arr.sharers_q[i]} !== 6'b0)
        $display("FAIL reset_entry%0d: got %b expected 0", i, {dut.u_arr.state_q[i], dut.u_arr.sharers_q[i]}); else passed++;
    end
  endtask

  task automatic test_read_miss();
    run_req(REQ_READ_MISS, 0, 3, 1, 0, 0);
    total++; if (o_reply_cyc !== 2) $display("FAIL rd_reply_cycle: got %0d expected 2", o_reply_cyc); else passed++;
    total++; if (o_excl !== 1'b0) $display("FAIL rd_exclusive: got %b expected 0", o_excl); else passed++;
    total++; if (o_rcpu !== 2'd0 || o_raddr !== 4'd3) $display("FAIL rd_reply_fields: got cpu %0d addr %0d expected 0/3", o_rcpu, o_raddr); else passed++;
    total++; if (o_inval_n + o_fetch_n !== 0) $display("FAIL rd_no_action: got %0d pulses expected 0", o_inval_n + o_fetch_n); else passed++;
    total++; if (dut.u_arr.state_q[3] !== 2'b10 || dut.u_arr.sharers_q[3] !== 4'b0001)
      $display("FAIL rd_entry: got %b/%b expected 10/0001", dut.u_arr.state_q[3], dut.u_arr.sharers_q[3]); else passed++;
    total++; if (o_idle_after !== 1'b1) $display("FAIL rd_idle_after: got %b expected 1", o_idle_after); else passed++;
  endtask

  task automatic test_inval();
    run_req(REQ_READ_MISS, 0, 5, 1, 0, 0);
    run_req(REQ_READ_MISS, 2, 5, 1, 0, 0);
    run_req(REQ_WRITE_MISS, 1, 5, 1, 0, 0);
    total++; if (o_inval_cyc !== 2 || o_inval_n !== 1) $display("FAIL inv_pulse: got cycle %0d count %0d expected 2/1", o_inval_cyc, o_inval_n); else passed++;
    total++; if (o_mask !== 4'b0101) $display("FAIL inv_mask: got %b expected 0101", o_mask); else passed++;
    total++; if (o_reply_cyc !== 3) $display("FAIL inv_reply_cycle: got %0d expected 3", o_reply_cyc); else passed++;
    total++; if (o_excl !== 1'b1) $display("FAIL inv_exclusive: got %b expected 1", o_excl); else passed++;
    total++; if (dut.u_arr.state_q[5] !== 2'b11 || dut.u_arr.sharers_q[5] !== 4'b0010)
      $display("FAIL inv_entry: got %b/%b expected 11/0010", dut.u_arr.state_q[5], dut.u_arr.sharers_q[5]); else passed++;
  endtask

  task automatic test_fetch_read();
    run_req(REQ_WRITE_MISS, 1, 7, 1, 0, 0);
    run_req(REQ_READ_MISS, 3, 7, 4, 0, 0);
    total++; if (o_fetch_cyc !== 2 || o_fetch_n !== 1) $display("FAIL fr_pulse: got cycle %0d count %0d expected 2/1", o_fetch_cyc, o_fetch_n); else passed++;
    total++; if (o_fcpu !== 2'd1 || o_finv !== 1'b0) $display("FAIL fr_fetch_fields: got cpu %0d inv %b expected 1/0", o_fcpu, o_finv); else passed++;
    total++; if (o_reply_cyc !== 7) $display("FAIL fr_reply_cycle: got %0d expected 7", o_reply_cyc); else passed++;
    total++; if (o_excl !== 1'b0) $display("FAIL fr_exclusive: got %b expected 0", o_excl); else passed++;
    total++; if (dut.u_arr.state_q[7] !== 2'b10 || dut.u_arr.sharers_q[7] !== 4'b1010)
      $display("FAIL fr_entry: got %b/%b expected 10/1010", dut.u_arr.state_q[7], dut.u_arr.sharers_q[7]); else passed++;
  endtask

  task automatic test_fetch_write_early();
    run_req(REQ_WRITE_MISS, 1, 7, 1, 0, 0);
    total++; if (o_mask !== 4'b1000) $display("FAIL fw_setup_mask: got %b expected 1000", o_mask); else passed++;
    run_req(REQ_WRITE_MISS, 2, 7, 3, 1, 0);
    total++; if (o_fcpu !== 2'd1 || o_finv !== 1'b1) $display("FAIL fw_fetch_fields: got cpu %0d inv %b expected 1/1", o_fcpu, o_finv); else passed++;
    total++; if (o_reply_cyc !== 6) $display("FAIL fw_early_wb_ignored: got reply cycle %0d expected 6", o_reply_cyc); else passed++;
    total++; if (o_excl !== 1'b1) $display("FAIL fw_exclusive: got %b expected 1", o_excl); else passed++;
    total++; if (dut.u_arr.state_q[7] !== 2'b11 || dut.u_arr.sharers_q[7] !== 4'b0100)
      $display("FAIL fw_entry: got %b/%b expected 11/0100", dut.u_arr.state_q[7], dut.u_arr.sharers_q[7]); else passed++;
  endtask

  task automatic test_reply_hold();
    run_req(REQ_READ_MISS, 3, 11, 1, 0, 5);
    total++; if (o_reply_cyc !== 2) $display("FAIL hold_reply_cycle: got %0d expected 2", o_reply_cyc); else passed++;
    total++; if (o_stable !== 1'b1) $display("FAIL hold_stable: got %b expected 1", o_stable); else passed++;
    total++; if (o_idle_after !== 1'b1) $display("FAIL hold_idle_after: got %b expected 1", o_idle_after); else passed++;
    total++; if (o_rcpu !== 2'd3 || o_raddr !== 4'd11) $display("FAIL hold_fields: got cpu %0d addr %0d expected 3/11", o_rcpu, o_raddr); else passed++;
  endtask

  task automatic test_none();
    run_req(REQ_NONE, 2, 3, 1, 0, 0);
    total++; if (o_reply_cyc !== -1) $display("FAIL none_reply: got cycle %0d expected -1", o_reply_cyc); else passed++;
    total++; if (bus.reqReady !== 1'b1) $display("FAIL none_ready: got %b expected 1", bus.reqReady); else passed++;
    total++; if (dut.u_arr.state_q[3] !== 2'b10 || dut.u_arr.sharers_q[3] !== 4'b0001)
      $display("FAIL none_entry: got %b/%b expected 10/0001", dut.u_arr.state_q[3], dut.u_arr.sharers_q[3]); else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic [1:0] t = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      int c = $urandom_range(0, NC - 1);
      int a = $urandom_range(0, 3);
      int d = $urandom_range(1, 5);
      int exp_cyc;
      run_req(t, c, a, d, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      exp_cyc = (t == REQ_NONE) ? -1 : (x_act == 1) ? 3 : (x_act == 2) ? 3 + d : 2;
      total++; if (o_reply_cyc !== exp_cyc) $display("FAIL rnd%0d_reply_cycle: got %0d expected %0d", n, o_reply_cyc, exp_cyc); else passed++;
      total++; if (o_inval_n !== (x_act == 1 ? 1 : 0) || (x_act == 1 && o_mask !== x_mask))
        $display("FAIL rnd%0d_inval: got n %0d mask %b expected act %0d mask %b", n, o_inval_n, o_mask, x_act, x_mask); else passed++;
      total++; if (o_fetch_n !== (x_act == 2 ? 1 : 0) || (x_act == 2 && (o_fcpu !== 2'(x_owner) || o_finv !== x_finv)))
        $display("FAIL rnd%0d_fetch: got n %0d cpu %0d inv %b expected act %0d cpu %0d inv %b", n, o_fetch_n, o_fcpu, o_finv, x_act, x_owner, x_finv); else passed++;
      if (t != REQ_NONE) begin
        total++; if (o_excl !== x_excl || o_rcpu !== 2'(c) || o_raddr !== 4'(a))
          $display("FAIL rnd%0d_reply: got excl %b cpu %0d addr %0d expected %b/%0d/%0d", n, o_excl, o_rcpu, o_raddr, x_excl, c, a); else passed++;
      end
      total++; if (dut.u_arr.state_q[a] !== m_st[a] || dut.u_arr.sharers_q[a] !== m_sh[a])
        $display("FAIL rnd%0d_entry: got %b/%b expected %b/%b", n, dut.u_arr.state_q[a], dut.u_arr.sharers_q[a], m_st[a], m_sh[a]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    run_req(REQ_WRITE_MISS, 0, 9, 1, 0, 0);
    @(negedge clk);
    bus.reqValid = 1; bus.reqType = REQ_READ_MISS; bus.reqCpu = 2'd1; bus.reqAddr = 4'd9;
    @(negedge clk);
    bus.reqValid = 0; bus.reqType = 0;
    @(negedge clk);
    total++; if (bus.fetchValid !== 1'b1) $display("FAIL rm_fetch: got %b expected 1", bus.fetchValid); else passed++;
    @(negedge clk);
    rst_n = 0;
    #1;
    total++; if ({bus.reqReady, bus.fetchValid, bus.replyValid, bus.invalValid, bus.replyExclusive} !== 5'b10000)
      $display("FAIL rm_outputs: got %b expected 10000", {bus.reqReady, bus.fetchValid, bus.replyValid, bus.invalValid, bus.replyExclusive}); else passed++;
    total++; if ({bus.addrOut, bus.fetchCpu, bus.replyCpu, bus.replyAddr} !== 12'b0)
      $display("FAIL rm_fields: got %h expected 0", {bus.addrOut, bus.fetchCpu, bus.replyCpu, bus.replyAddr}); else passed++;
    total++; if (dut.u_arr.state_q[9] !== 2'b00 || dut.u_arr.sharers_q[9] !== 4'b0)
      $display("FAIL rm_entry: got %b/%b expected 00/0000", dut.u_arr.state_q[9], dut.u_arr.sharers_q[9]); else passed++;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < NB; i++) begin m_st[i] = 0; m_sh[i] = 0; end
    repeat (3) @(negedge clk);
    total++; if (bus.replyValid !== 1'b0 || bus.reqReady !== 1'b1) $display("FAIL rm_no_reply: got valid %b ready %b expected 0/1", bus.replyValid, bus.reqReady); else passed++;
  endtask

`ifdef DIRECTORY_STATS_EN
  task automatic test_stats();
    total++; if ({s_req, s_inv, s_fet} !== 48'b0) $display("FAIL st_reset: got %h expected 0", {s_req, s_inv, s_fet}); else passed++;
    run_req(REQ_WRITE_MISS, 0, 1, 1, 0, 0);
    run_req(REQ_READ_MISS, 1, 1, 2, 0, 0);
    run_req(REQ_NONE, 3, 1, 1, 0, 0);
    run_req(REQ_WRITE_MISS, 2, 1, 1, 0, 0);
    total++; if (s_req !== 16'd3) $display("FAIL st_req: got %0d expected 3", s_req); else passed++;
    total++; if (s_inv !== 16'd1) $display("FAIL st_inval: got %0d expected 1", s_inv); else passed++;
    total++; if (s_fet !== 16'd1) $display("FAIL st_fetch: got %0d expected 1", s_fet); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_read_miss();
    test_inval();
    test_fetch_read();
    test_fetch_write_early();
    test_reply_hold();
    test_none();
    test_random();
    test_reset_mid();
`ifdef DIRECTORY_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
